// File: rtl/snoop_result_gen.sv
// snoop_result_gen
//   Sequential snoop-result lookup for the L2 bus model. A request is accepted on a
//   valid/ready handshake. Its result comes from a programmable 2-bit table indexed by the
//   low address bits. The result is presented LATENCY cycles after acceptance and is held
//   until the consumer takes it. Saturating per-result counters record every delivered
//   result.
//
// Ports
//   clk, rst_n                  clock, asynchronous active-low reset
//   i_req_valid / o_req_ready   request handshake
//   i_req_addr, i_req_op        snooped address and bus op (op is echoed, not decoded)
//   o_rsp_valid / i_rsp_ready   response handshake
//   o_rsp_result                00 HIT, 01 HITM, 10 NOHIT
//   o_rsp_addr, o_rsp_op        captured request fields
//   i_cfg_we, i_cfg_index,
//   i_cfg_data                  table write port (data 11 is ignored)
//   o_hit_cnt, o_hitm_cnt,
//   o_nohit_cnt                 saturating delivered-result counters
module snoop_result_gen #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned SEL_BITS   = 4,
  parameter int unsigned LATENCY    = 2,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_req_valid,
  output logic                  o_req_ready,
  input  logic [ADDR_WIDTH-1:0] i_req_addr,
  input  logic [7:0]            i_req_op,
  output logic                  o_rsp_valid,
  input  logic                  i_rsp_ready,
  output logic [1:0]            o_rsp_result,
  output logic [ADDR_WIDTH-1:0] o_rsp_addr,
  output logic [7:0]            o_rsp_op,
  input  logic                  i_cfg_we,
  input  logic [SEL_BITS-1:0]   i_cfg_index,
  input  logic [1:0]            i_cfg_data,
  output logic [CNT_WIDTH-1:0]  o_hit_cnt,
  output logic [CNT_WIDTH-1:0]  o_hitm_cnt,
  output logic [CNT_WIDTH-1:0]  o_nohit_cnt
);

  localparam int unsigned Depth = 2 ** SEL_BITS;
  localparam bit          LatOne = (LATENCY == 1);
  // WAIT spends LatLoad+1 cycles, so together with the accept and RESP-entry edges the
  // response appears exactly LATENCY edges after acceptance.
  localparam logic [3:0]  LatLoad = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

  localparam logic [1:0] ResHit   = 2'b00;
  localparam logic [1:0] ResHitm  = 2'b01;
  localparam logic [1:0] ResNohit = 2'b10;

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e                r_state, w_state_next;
  logic [3:0]            r_lat_cnt, w_lat_cnt_next;
  logic [1:0]            r_table [Depth];
  logic [1:0]            r_rsp_result;
  logic [ADDR_WIDTH-1:0] r_rsp_addr;
  logic [7:0]            r_rsp_op;
  logic [CNT_WIDTH-1:0]  r_hit_cnt, r_hitm_cnt, r_nohit_cnt;
  logic                  w_accept;
  logic                  w_rsp_hs;

  function automatic logic [1:0] default_entry(input int unsigned idx);
    case (idx)
      2, 8:    default_entry = ResHitm;
      4, 12:   default_entry = ResNohit;
      default: default_entry = ResHit;
    endcase
  endfunction

  assign o_req_ready = (r_state == StIdle);
  assign o_rsp_valid = (r_state == StResp);
  assign w_accept    = o_req_ready & i_req_valid;
  assign w_rsp_hs    = o_rsp_valid & i_rsp_ready;

  always_comb begin
    w_state_next   = r_state;
    w_lat_cnt_next = r_lat_cnt;
    unique case (r_state)
      StIdle: begin
        if (i_req_valid) begin
          if (LatOne) begin
            w_state_next = StResp;
          end else begin
            w_lat_cnt_next = LatLoad;
            w_state_next   = StWait;
          end
        end
      end
      StWait: begin
        if (r_lat_cnt == 4'd0) begin
          w_state_next = StResp;
        end else begin
          w_lat_cnt_next = r_lat_cnt - 4'd1;
        end
      end
      StResp: begin
        if (i_rsp_ready) w_state_next = StIdle;
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= StIdle;
      r_lat_cnt <= 4'd0;
    end else begin
      r_state   <= w_state_next;
      r_lat_cnt <= w_lat_cnt_next;
    end
  end

  // The capture below reads the pre-edge table contents, so a same-cycle write does not
  // affect the request being accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < Depth; i++) r_table[i] <= default_entry(i);
    end else if (i_cfg_we && (i_cfg_data != 2'b11)) begin
      r_table[i_cfg_index] <= i_cfg_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp_result <= 2'b00;
      r_rsp_addr   <= '0;
      r_rsp_op     <= 8'h00;
    end else if (w_accept) begin
      r_rsp_result <= r_table[i_req_addr[SEL_BITS-1:0]];
      r_rsp_addr   <= i_req_addr;
      r_rsp_op     <= i_req_op;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hit_cnt   <= '0;
      r_hitm_cnt  <= '0;
      r_nohit_cnt <= '0;
    end else if (w_rsp_hs) begin
      case (r_rsp_result)
        ResHit:   if (r_hit_cnt != '1) r_hit_cnt <= r_hit_cnt + 1'b1;
        ResHitm:  if (r_hitm_cnt != '1) r_hitm_cnt <= r_hitm_cnt + 1'b1;
        ResNohit: if (r_nohit_cnt != '1) r_nohit_cnt <= r_nohit_cnt + 1'b1;
        default:  ;
      endcase
    end
  end

  assign o_rsp_result = r_rsp_result;
  assign o_rsp_addr   = r_rsp_addr;
  assign o_rsp_op     = r_rsp_op;
  assign o_hit_cnt    = r_hit_cnt;
  assign o_hitm_cnt   = r_hitm_cnt;
  assign o_nohit_cnt  = r_nohit_cnt;

endmodule

// File: doc/snoop_result_gen.md
Name: snoop_result_gen

Overview:
- Parametrised, sequential successor to the combinational snoop-result lookup used by the L2 cache simulator's bus model.
- Accepts one snoop request at a time over a valid/ready handshake and looks up a 2-bit snoop result in a programmable table indexed by low address bits.
- Returns the result after a configurable latency and holds it until consumed.
- Keeps saturating per-result statistics for the simulator's end-of-run report.

Parameters:
- ADDR_WIDTH, 32, width of snoop address.
- SEL_BITS, 4, number of low address bits used as table index (table depth 2**SEL_BITS); legal range 4..8.
- LATENCY, 2, cycles from request acceptance to rsp_valid assertion; legal range 1..15.
- CNT_WIDTH, 16, width of each statistics counter.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  reset; asynchronous assertion, active-low.
- req_valid  input  1  snoop request present.
- req_ready  output  1  block can accept a request.
- req_addr  input  ADDR_WIDTH  snooped address.
- req_op  input  8  bus operation code; captured and echoed, not decoded.
- rsp_valid  output  1  result available.
- rsp_ready  input  1  consumer accepts result.
- rsp_result  output  2  00 HIT, 01 HITM, 10 NOHIT.
- rsp_addr  output  ADDR_WIDTH  captured address.
- rsp_op  output  8  captured operation.
- cfg_we  input  1  table write strobe.
- cfg_index  input  SEL_BITS  table entry to write.
- cfg_data  input  2  new entry value.
- hit_cnt  output  CNT_WIDTH  delivered HIT count.
- hitm_cnt  output  CNT_WIDTH  delivered HITM count.
- nohit_cnt  output  CNT_WIDTH  delivered NOHIT count.

Behaviour:
- Encoding: 00 HIT, 01 HITM, 10 NOHIT; 11 reserved.
- Reset (rst_n low, asynchronous) puts the block in IDLE:
  - req_ready=1, rsp_valid=0, rsp_result=00, rsp_addr=0, rsp_op=0, all counters 0, latency counter 0.
  - Table defaults: index 2 and 8 -> 01; index 4 and 12 -> 10; every other index -> 00.
  - Reset mid-operation discards any in-flight request with no response.
- Table writes:
  - When cfg_we=1, entry[cfg_index] takes cfg_data at the clock edge.
  - cfg_data=11 is ignored and the entry is unchanged.
  - Writes are permitted in every FSM state.
- FSM states: IDLE, WAIT, RESP.
  - IDLE: req_ready=1. On req_valid=1, capture req_addr, req_op and entry[req_addr[SEL_BITS-1:0]] using the table value before any same-cycle cfg write. Then:
    - LATENCY=1: go to RESP.
    - LATENCY>1: load the latency counter with LATENCY-2 and go to WAIT.
  - WAIT: req_ready=0. Decrement the counter each cycle; when the counter is 0, go to RESP.
  - RESP: rsp_valid=1 and req_ready=0. rsp_result, rsp_addr and rsp_op are held stable. On rsp_ready=1, go to IDLE and deassert rsp_valid next cycle.
- Latency: rsp_valid rises exactly LATENCY cycles after the accepting edge.
- Throughput: no acceptance in the same cycle as the response handshake, so minimum request spacing is LATENCY+1 cycles.
- The captured result is immune to table writes after capture.
- req_valid while req_ready=0 is ignored; the requester must hold it.
- Statistics:
  - On each rsp handshake, increment the counter matching rsp_result.
  - Counters saturate at all-ones.
  - Counters are cleared only by reset.
- rsp_ready while rsp_valid=0 has no effect.

Test Plan:
- Reset defaults, LATENCY=2: requests to addresses 0x00000002, 0x00000008, 0x0000000C, 0x00000005 with rsp_ready=1 -> results 01, 01, 10, 00, each rsp_valid 2 cycles after accept. Afterwards hitm_cnt=2, nohit_cnt=1, hit_cnt=1.
- Backpressure: request addr 0x00000004 with rsp_ready=0 for 5 cycles -> rsp_valid stays 1 with result 10 and rsp_addr stable; req_ready=0 throughout; a second req_valid is not accepted until 1 cycle after the handshake.
- Table reprogram: write index 5 = 01, then request 0x00000015 -> 01. A same-cycle write of index 5 = 10 during acceptance still returns 01; the next request returns 10. Writing 11 leaves the entry unchanged.
- Latency bounds: LATENCY=1 -> rsp_valid the cycle after accept. LATENCY=15 -> rsp_valid exactly 15 cycles after accept. SEL_BITS=8 -> addr 0x000000F2 uses index 0xF2, which defaults to 00.
- Async reset in WAIT: assert rst_n=0 mid-latency -> rsp_valid=0 and req_ready=1 immediately; no response and no counter change after release.
- Saturation: CNT_WIDTH=4, 17 HIT responses -> hit_cnt=15, other counters 0.
